// File: rtl/riscv_pkg.sv
// Shared RV32I-subset constants: ALU operation codes, major opcodes, control FSM
// state encoding and the arithmetic funct3 -> ALU operation mapping.
package riscv_pkg;

    localparam logic [3:0] ALUOP_AND = 4'b0000;
    localparam logic [3:0] ALUOP_OR  = 4'b0001;
    localparam logic [3:0] ALUOP_ADD = 4'b0010;
    localparam logic [3:0] ALUOP_SUB = 4'b0110;
    localparam logic [3:0] ALUOP_SLT = 4'b0111;
    localparam logic [3:0] ALUOP_SRL = 4'b1000;
    localparam logic [3:0] ALUOP_SLL = 4'b1001;
    localparam logic [3:0] ALUOP_SRA = 4'b1010;
    localparam logic [3:0] ALUOP_XOR = 4'b1101;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_BEQ    = 7'b1100011;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    // The alternate bit selects SUB only for R-type; it selects SRA for both formats.
    function automatic logic [3:0] arith_alu_op(input logic [2:0] funct3,
                                                input logic       f7_alt,
                                                input logic       is_rtype);
        case (funct3)
            3'b000:  return (is_rtype && f7_alt) ? ALUOP_SUB : ALUOP_ADD;
            3'b001:  return ALUOP_SLL;
            3'b010:  return ALUOP_SLT;
            3'b100:  return ALUOP_XOR;
            3'b101:  return f7_alt ? ALUOP_SRA : ALUOP_SRL;
            3'b110:  return ALUOP_OR;
            3'b111:  return ALUOP_AND;
            default: return ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct3/funct7 into the ALU operation code,
// the immediate-operand select and a flag marking the encoding as supported.
module alu_op_decode
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_op,
    output logic       alu_src,
    output logic       supported
);

    always_comb begin
        alu_op    = ALUOP_ADD;
        alu_src   = 1'b0;
        supported = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                alu_op    = arith_alu_op(funct3, funct7[5], 1'b1);
                supported = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            end
            OP_IARITH: begin
                alu_op  = arith_alu_op(funct3, funct7[5], 1'b0);
                alu_src = 1'b1;
            end
            OP_LW, OP_SW: alu_src = 1'b1;
            OP_BEQ:       alu_op  = ALUOP_SUB;
            default:      supported = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle IF/ID/EX/MEM/WB control unit for the RV32I-subset datapath.
// Optional illegal-instruction trap: define MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN.
module multicycle_control
    import riscv_pkg::*;
#(
    parameter int unsigned IF_WAIT = 0
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic        mem_write,
    output logic        reg_write,
    output logic        load_pc,
    output logic        pc_src,
    output logic [2:0]  state
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    ,
    output logic        illegal
`endif
);

    localparam logic [2:0] IF_WAIT_C = 3'(IF_WAIT);

    state_t      state_q, state_n;
    logic [2:0]  wait_q;
    logic [31:0] ir_q;
    logic [3:0]  alu_op_q;
    logic        alu_src_q;
    logic        branch_taken;
    logic        if_done;
    logic        trap;
    logic [3:0]  dec_alu_op;
    logic        dec_alu_src;
    logic        dec_supported;
    logic        is_rtype, is_iarith, is_lw, is_sw, is_beq;

    alu_op_decode u_decode (
        .opcode    (ir_q[6:0]),
        .funct3    (ir_q[14:12]),
        .funct7    (ir_q[31:25]),
        .alu_op    (dec_alu_op),
        .alu_src   (dec_alu_src),
        .supported (dec_supported)
    );

    assign is_rtype  = (ir_q[6:0] == OP_RTYPE);
    assign is_iarith = (ir_q[6:0] == OP_IARITH);
    assign is_lw     = (ir_q[6:0] == OP_LW);
    assign is_sw     = (ir_q[6:0] == OP_SW);
    assign is_beq    = (ir_q[6:0] == OP_BEQ);
    assign if_done   = (wait_q == IF_WAIT_C);

`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    assign trap    = !dec_supported;
    assign illegal = (state_q == S_ID) && trap;
    logic unused_ir_fields;
    assign unused_ir_fields = ^{ir_q[24:15], ir_q[11:7]};
`else
    assign trap = 1'b0;
    logic unused_ir_fields;
    assign unused_ir_fields = ^{ir_q[24:15], ir_q[11:7], dec_supported};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IF;
        else      state_q <= state_n;
    end

    // Strobes decode from the async-reset state register, so they drop the moment rst falls.
    always_comb begin
        state_n    = state_q;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        load_pc    = 1'b0;
        pc_src     = 1'b0;
        mem_to_reg = 1'b0;
        case (state_q)
            S_IF:  if (if_done) state_n = S_ID;
            S_ID:  state_n = trap ? S_IF : S_EX;
            S_EX: begin
                state_n    = S_MEM;
                mem_to_reg = is_lw;
            end
            S_MEM: begin
                state_n    = S_WB;
                mem_to_reg = is_lw;
                mem_write  = is_sw;
            end
            S_WB: begin
                state_n    = S_IF;
                mem_to_reg = is_lw;
                reg_write  = is_rtype | is_iarith | is_lw;
                load_pc    = 1'b1;
                pc_src     = branch_taken;
            end
            default: state_n = S_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q       <= 3'd0;
            ir_q         <= 32'd0;
            alu_op_q     <= ALUOP_ADD;
            alu_src_q    <= 1'b0;
            branch_taken <= 1'b0;
        end else begin
            // Counter sits at zero outside IF, so every fetch starts a fresh stall count.
            wait_q <= (state_q == S_IF && !if_done) ? wait_q + 3'd1 : 3'd0;
            if (state_q == S_IF && if_done) ir_q <= instr;
            if (state_q == S_ID && state_n == S_EX) begin
                alu_op_q  <= dec_alu_op;
                alu_src_q <= dec_alu_src;
            end
            if (state_q == S_EX)      branch_taken <= is_beq & zero;
            else if (state_q == S_IF) branch_taken <= 1'b0;
        end
    end

    assign alu_op  = alu_op_q;
    assign alu_src = alu_src_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed and randomized bench for multicycle_control against a per-instruction
// behavioural model; a second instance checks the IF stall length with IF_WAIT=3.
module tb_multicycle_control;

    localparam int W = 0;
    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BAD = 5;
    localparam logic [3:0] ARITH [8] = '{4'b0010, 4'b1001, 4'b0111, 4'b0010,
                                         4'b1101, 4'b1000, 4'b0001, 4'b0000};

    logic        clk, rst, zero;
    logic [31:0] instr, instr_w;
    logic [3:0]  alu_op, alu_op_w;
    logic        alu_src, mem_to_reg, mem_write, reg_write, load_pc, pc_src;
    logic        alu_src_w, mem_to_reg_w, mem_write_w, reg_write_w, load_pc_w, pc_src_w;
    logic [2:0]  state, state_w;
    logic        illegal, illegal_w;

    int tests = 0;
    int fails = 0;
    int instr_no = 0;
    int cyc_no = 0;
    logic [3:0] cur_op = 4'b0010;
    logic       cur_src = 1'b0;
    logic [2:0] exp_q[$];

    multicycle_control #(.IF_WAIT(W)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .alu_op(alu_op), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .mem_write(mem_write), .reg_write(reg_write), .load_pc(load_pc),
        .pc_src(pc_src), .state(state)
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    multicycle_control #(.IF_WAIT(3)) dut_w (
        .clk(clk), .rst(rst), .instr(instr_w), .zero(1'b0),
        .alu_op(alu_op_w), .alu_src(alu_src_w), .mem_to_reg(mem_to_reg_w),
        .mem_write(mem_write_w), .reg_write(reg_write_w), .load_pc(load_pc_w),
        .pc_src(pc_src_w), .state(state_w)
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
        , .illegal(illegal_w)
`endif
    );

`ifndef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    assign illegal   = 1'b0;
    assign illegal_w = 1'b0;
`endif

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s instr#%0d cyc%0d observed=%h expected=%h",
                     tag, instr_no, cyc_no, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Reference model: what the instruction is, which ALU op/operand it needs, and
    // whether the trap build treats it as illegal.
    function automatic void classify(input logic [31:0] i, output logic [3:0] op,
                                     output logic src, output int kind, output logic bad);
        logic [2:0] f3;
        f3   = i[14:12];
        op   = 4'b0010;
        src  = 1'b0;
        kind = K_BAD;
        bad  = 1'b0;
        case (i[6:0])
            7'b0110011: begin
                kind = K_R;
                op   = ARITH[f3];
                if (i[30] && f3 == 3'd0) op = 4'b0110;
                if (i[30] && f3 == 3'd5) op = 4'b1010;
                bad  = !(i[31:25] == 7'h00 || i[31:25] == 7'h20);
            end
            7'b0010011: begin
                kind = K_I;
                src  = 1'b1;
                op   = ARITH[f3];
                if (i[30] && f3 == 3'd5) op = 4'b1010;
            end
            7'b0000011: begin kind = K_LW;  src = 1'b1; end
            7'b0100011: begin kind = K_SW;  src = 1'b1; end
            7'b1100011: begin kind = K_BEQ; op = 4'b0110; end
            default:    bad = 1'b1;
        endcase
    endfunction

    // Driver + scoreboard: called at a negedge with the DUT in the first IF cycle.
    // abort_phase >= 0 pulls rst low during that phase and checks the abort.
    task automatic run_instr(input logic [31:0] i, input logic z, input int abort_phase);
        logic [3:0] eop;
        logic       esrc, bad, trap;
        int         kind, n, ph;
        logic [2:0] es;
        classify(i, eop, esrc, kind, bad);
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
        trap = bad;
`else
        trap = 1'b0;
`endif
        n = trap ? W + 2 : W + 5;
        for (int c = 0; c < n; c++) exp_q.push_back((c <= W) ? 3'd0 : 3'(c - W));
        instr_no++;
        for (int c = 0; c < n; c++) begin
            cyc_no = c;
            ph = (c <= W) ? 0 : c - W;
            es = exp_q.pop_front();
            if (ph == 2) begin
                cur_op  = eop;
                cur_src = esrc;
            end
            chk("state", {1'b0, state}, {1'b0, es});
            chk("alu_op", alu_op, cur_op);
            chk("alu_src", {3'b0, alu_src}, {3'b0, cur_src});
            chk("mem_write", {3'b0, mem_write}, {3'b0, ph == 3 && kind == K_SW});
            chk("reg_write", {3'b0, reg_write},
                {3'b0, ph == 4 && (kind == K_R || kind == K_I || kind == K_LW)});
            chk("mem_to_reg", {3'b0, mem_to_reg}, {3'b0, kind == K_LW && ph >= 2});
            chk("load_pc", {3'b0, load_pc}, {3'b0, ph == 4});
            chk("pc_src", {3'b0, pc_src}, {3'b0, ph == 4 && kind == K_BEQ && z});
            chk("illegal", {3'b0, illegal}, {3'b0, trap && ph == 1});
            if (ph == abort_phase) begin
                rst = 1'b0;
                #1;
                chk("abort_mem_write", {3'b0, mem_write}, 4'd0);
                chk("abort_reg_write", {3'b0, reg_write}, 4'd0);
                chk("abort_load_pc", {3'b0, load_pc}, 4'd0);
                chk("abort_mem_to_reg", {3'b0, mem_to_reg}, 4'd0);
                chk("abort_state", {1'b0, state}, 4'd0);
                chk("abort_alu_op", alu_op, 4'b0010);
                cur_op  = 4'b0010;
                cur_src = 1'b0;
                exp_q.delete();
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            instr = (c == W) ? i : $urandom();
            zero  = (ph == 2) ? z : 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 8))
            0, 1: begin r[6:0] = 7'b0110011; r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
            2, 3: r[6:0] = 7'b0010011;
            4:    r[6:0] = 7'b0000011;
            5:    r[6:0] = 7'b0100011;
            6:    r[6:0] = 7'b1100011;
            7:    r[6:0] = 7'b0110011;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        int cnt;
        rst     = 1'b0;
        instr   = 32'd0;
        instr_w = 32'h0000_0013;
        zero    = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", {1'b0, state}, 4'd0);
        chk("reset_alu_op", alu_op, 4'b0010);
        chk("reset_strobes", {1'b0, mem_write, reg_write, load_pc}, 4'd0);
        chk("reset_misc", {1'b0, pc_src, mem_to_reg, alu_src}, 4'd0);
        rst = 1'b1;

        run_instr(32'h0020_81B3, 1'b0, -1);  // add
        run_instr(32'h4020_81B3, 1'b1, -1);  // sub
        run_instr(32'h4020_D1B3, 1'b0, -1);  // sra
        run_instr(32'h0020_D1B3, 1'b0, -1);  // srl
        run_instr(32'h0020_A023, 1'b0, -1);  // sw
        run_instr(32'h0020_8463, 1'b1, -1);  // beq taken
        run_instr(32'h0020_8463, 1'b0, -1);  // beq not taken
        run_instr(32'h0000_A183, 1'b1, -1);  // lw
        run_instr(32'h4050_D193, 1'b0, -1);  // srai
        run_instr(32'h4000_8193, 1'b0, -1);  // addi with bit 30 set stays ADD
        run_instr(32'hFFFF_FFFF, 1'b1, -1);  // unsupported
        run_instr(32'h6020_81B3, 1'b0, -1);  // R-type with odd funct7
        run_instr(32'h0020_A023, 1'b0, 3);   // sw aborted in MEM
        run_instr(32'h0020_81B3, 1'b0, -1);

        for (int k = 0; k < 150; k++)
            run_instr(rand_instr(), 1'($urandom_range(0, 1)), -1);

        // IF_WAIT=3 instance: IF must last four cycles, then one cycle per later state
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            cnt = 0;
            while (state_w == 3'd0 && cnt < 20) begin
                cnt++;
                @(negedge clk);
            end
            chk("wait_if_len", 4'(cnt), 4'd4);
            for (int s = 1; s <= 4; s++) begin
                chk("wait_state", {1'b0, state_w}, 4'(s));
                chk("wait_load_pc", {3'b0, load_pc_w}, {3'b0, s == 4});
                @(negedge clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
